// File: rtl/id_pipe.sv
// id_pipe -- single-stage MIPS-subset instruction decoder with a registered
// output bundle and valid/ready handshakes on both sides.
//
// Decodes ADDIU, ORI, LUI and SPECIAL ADDU/AND/OR. Register-file read
// addresses come combinationally from the presented instruction. Operands are
// resolved in the same cycle and captured together with the rest of the
// decoded bundle on the next rising edge.
//
// Build option: define ID_PIPE_FORWARD_EN to bypass ex_wdata into sources
// that the EX-stage writeback targets. Without it such an instruction is held
// off (in_ready low) until the EX writeback no longer collides.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready               fetch-side handshake
//   inst_addr, inst                 presented instruction and its address
//   rf_raddr1/2, rf_rdata1/2        register-file read port pair
//   ex_wen, ex_waddr, ex_wdata      writeback of the instruction now in EX
//   flush                           drop held and presented instruction
//   out_valid/out_ready             EX-side handshake
//   out_pc, out_alu_op, out_src1, out_src2,
//   out_waddr, out_wen, out_illegal registered decoded bundle
module id_pipe #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        inst_addr,
    input  logic [31:0]        inst,
    output logic [RADDR_W-1:0] rf_raddr1,
    output logic [RADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0]  rf_rdata1,
    input  logic [DATA_W-1:0]  rf_rdata2,
    input  logic               ex_wen,
    input  logic [RADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [2:0]         out_alu_op,
    output logic [DATA_W-1:0]  out_src1,
    output logic [DATA_W-1:0]  out_src2,
    output logic [RADDR_W-1:0] out_waddr,
    output logic               out_wen,
    output logic               out_illegal
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_AND = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;
    localparam logic [2:0] ALU_NOP = 3'd7;

    function automatic logic signed [DATA_W-1:0] imm_sext(input logic signed [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

    function automatic logic [DATA_W-1:0] imm_zext(input logic [15:0] imm);
        return {{(DATA_W-16){1'b0}}, imm};
    endfunction

    function automatic logic [DATA_W-1:0] imm_upper(input logic [15:0] imm);
        return {{(DATA_W-32){1'b0}}, imm, 16'h0000};
    endfunction

    // ---- stage p0: combinational decode of the presented instruction ----
    logic [5:0]         op_p0;
    logic [5:0]         fn_p0;
    logic [RADDR_W-1:0] rs_p0;
    logic [RADDR_W-1:0] rt_p0;
    logic [RADDR_W-1:0] rd_p0;
    logic [15:0]        imm_p0;

    assign op_p0  = inst[31:26];
    assign fn_p0  = inst[5:0];
    assign rs_p0  = RADDR_W'(inst[25:21]);
    assign rt_p0  = RADDR_W'(inst[20:16]);
    assign rd_p0  = RADDR_W'(inst[15:11]);
    assign imm_p0 = inst[15:0];

    assign rf_raddr1 = rs_p0;
    assign rf_raddr2 = rt_p0;

    logic [2:0]         alu_p0;
    logic               ill_p0;
    logic               use_rs_p0;
    logic               use_rt_p0;
    logic [RADDR_W-1:0] wa_p0;
    logic [DATA_W-1:0]  immv_p0;

    always_comb begin
        alu_p0    = ALU_NOP;
        ill_p0    = 1'b1;
        use_rs_p0 = 1'b0;
        use_rt_p0 = 1'b0;
        wa_p0     = '0;
        immv_p0   = '0;
        case (op_p0)
            OP_ADDIU: begin
                alu_p0 = ALU_ADD; ill_p0 = 1'b0; use_rs_p0 = 1'b1;
                wa_p0 = rt_p0; immv_p0 = imm_sext(imm_p0);
            end
            OP_ORI: begin
                alu_p0 = ALU_OR; ill_p0 = 1'b0; use_rs_p0 = 1'b1;
                wa_p0 = rt_p0; immv_p0 = imm_zext(imm_p0);
            end
            OP_LUI: begin
                alu_p0 = ALU_LUI; ill_p0 = 1'b0;
                wa_p0 = rt_p0; immv_p0 = imm_upper(imm_p0);
            end
            OP_SPECIAL: begin
                case (fn_p0)
                    FN_ADDU: alu_p0 = ALU_ADD;
                    FN_AND:  alu_p0 = ALU_AND;
                    FN_OR:   alu_p0 = ALU_OR;
                    default: alu_p0 = ALU_NOP;
                endcase
                if (alu_p0 != ALU_NOP) begin
                    ill_p0 = 1'b0; use_rs_p0 = 1'b1; use_rt_p0 = 1'b1;
                    wa_p0 = rd_p0;
                end
            end
            default: ;
        endcase
    end

    // Collision with the EX writeback only matters for sources actually read;
    // register 0 is hard-wired and never collides.
    logic hit1_p0;
    logic hit2_p0;
    logic hazard_p0;
    logic stall_p0;

    assign hit1_p0   = ex_wen && (ex_waddr != '0) && use_rs_p0 && (ex_waddr == rs_p0);
    assign hit2_p0   = ex_wen && (ex_waddr != '0) && use_rt_p0 && (ex_waddr == rt_p0);
    assign hazard_p0 = in_valid && (hit1_p0 || hit2_p0);

    logic [DATA_W-1:0] rs_val_p0;
    logic [DATA_W-1:0] rt_val_p0;

`ifdef ID_PIPE_FORWARD_EN
    assign stall_p0  = 1'b0;
    assign rs_val_p0 = (rs_p0 == '0) ? '0 : (hit1_p0 ? ex_wdata : rf_rdata1);
    assign rt_val_p0 = (rt_p0 == '0) ? '0 : (hit2_p0 ? ex_wdata : rf_rdata2);
`else
    assign stall_p0  = hazard_p0;
    assign rs_val_p0 = (rs_p0 == '0) ? '0 : rf_rdata1;
    assign rt_val_p0 = (rt_p0 == '0) ? '0 : rf_rdata2;
`endif

    // ex_wdata is only consumed by the bypass build; shamt bits never are.
    logic unused_bits;
    assign unused_bits = ^{ex_wdata, inst[10:6]};

    logic [DATA_W-1:0] src1_p0;
    logic [DATA_W-1:0] src2_p0;

    assign src1_p0 = use_rs_p0 ? rs_val_p0 : '0;
    assign src2_p0 = use_rt_p0 ? rt_val_p0 : immv_p0;

    assign in_ready = !rst && !flush && !stall_p0 && (!out_valid || out_ready);

    // ---- stage p1: registered output bundle ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_alu_op  <= ALU_NOP;
            out_src1    <= '0;
            out_src2    <= '0;
            out_waddr   <= '0;
            out_wen     <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid   <= 1'b1;
            out_pc      <= inst_addr;
            out_alu_op  <= alu_p0;
            out_src1    <= src1_p0;
            out_src2    <= src2_p0;
            out_waddr   <= wa_p0;
            out_wen     <= !ill_p0 && (wa_p0 != '0);
            out_illegal <= ill_p0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_pipe.sv
module tb_id_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst = '0;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1 = '0, rf_rdata2 = '0;
    logic        ex_wen = 1'b0;
    logic [4:0]  ex_waddr = '0;
    logic [31:0] ex_wdata = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [2:0]  out_alu_op;
    logic [31:0] out_src1, out_src2;
    logic [4:0]  out_waddr;
    logic        out_wen, out_illegal;

    always #5 clk = ~clk;

    id_pipe #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst_addr(inst_addr), .inst(inst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_alu_op(out_alu_op),
        .out_src1(out_src1), .out_src2(out_src2),
        .out_waddr(out_waddr), .out_wen(out_wen), .out_illegal(out_illegal)
    );

`ifdef ID_PIPE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  alu;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  wa;
        logic        wen;
        logic        ill;
    } bundle_t;

    localparam bundle_t RST_B = '{pc: 32'h0, alu: 3'd7, s1: 32'h0, s2: 32'h0,
                                  wa: 5'h0, wen: 1'b0, ill: 1'b0};

    int      n_cmp = 0;
    int      n_err = 0;
    bundle_t sb[$];
    logic    exp_valid = 1'b0;
    logic    exp_known = 1'b0;
    logic    after_rst = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    // Reference decoder: expected bundle plus whether a stall-type hazard exists.
    function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] d1, input logic [31:0] d2,
                                      input logic ew, input logic [4:0] ea,
                                      input logic [31:0] ed, output logic hz);
        bundle_t b;
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        logic use_rs, use_rt;
        logic [31:0] v1, v2;
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; imm = ins[15:0];
        b = '{pc: pc, alu: 3'd7, s1: 32'h0, s2: 32'h0, wa: 5'h0, wen: 1'b0, ill: 1'b1};
        use_rs = 1'b0; use_rt = 1'b0;
        if (ins[31:26] == 6'b001001) begin
            b.alu = 3'd0; b.ill = 1'b0; use_rs = 1'b1; b.wa = rt;
            b.s2 = {{16{imm[15]}}, imm};
        end else if (ins[31:26] == 6'b001101) begin
            b.alu = 3'd2; b.ill = 1'b0; use_rs = 1'b1; b.wa = rt;
            b.s2 = {16'h0, imm};
        end else if (ins[31:26] == 6'b001111) begin
            b.alu = 3'd3; b.ill = 1'b0; b.wa = rt;
            b.s2 = {imm, 16'h0};
        end else if (ins[31:26] == 6'b000000 &&
                     (ins[5:0] == 6'b100001 || ins[5:0] == 6'b100100 || ins[5:0] == 6'b100101)) begin
            b.alu = (ins[5:0] == 6'b100001) ? 3'd0 : (ins[5:0] == 6'b100100) ? 3'd1 : 3'd2;
            b.ill = 1'b0; use_rs = 1'b1; use_rt = 1'b1; b.wa = rd;
        end
        hz = ew && (ea != 5'd0) && ((use_rs && ea == rs) || (use_rt && ea == rt));
        v1 = (rs == 5'd0) ? 32'h0 : ((FWD && ew && ea == rs) ? ed : d1);
        v2 = (rt == 5'd0) ? 32'h0 : ((FWD && ew && ea == rt) ? ed : d2);
        if (use_rs) b.s1 = v1;
        if (use_rt) b.s2 = v2;
        b.wen = !b.ill && (b.wa != 5'd0);
        return b;
    endfunction

    // One clock: inputs already driven; check at negedge, advance the model, then
    // return just after the next rising edge.
    task automatic tick();
        bundle_t nb;
        logic hz, rdy;
        @(negedge clk);
        nb  = model(inst, inst_addr, rf_rdata1, rf_rdata2, ex_wen, ex_waddr, ex_wdata, hz);
        rdy = !rst && !flush && !(in_valid && hz && !FWD) && (!exp_valid || out_ready);
        check("in_ready", 128'(in_ready), 128'(rdy));
        check("rf_raddr", 128'({rf_raddr1, rf_raddr2}), 128'({inst[25:21], inst[20:16]}));
        if (exp_known) begin
            check("out_valid", 128'(out_valid), 128'(exp_valid));
            if (after_rst)
                check("reset_bundle", 128'({out_pc, out_alu_op, out_src1, out_src2, out_waddr,
                      out_wen, out_illegal}), 128'(RST_B));
            else if (exp_valid && sb.size() > 0)
                check("bundle", 128'({out_pc, out_alu_op, out_src1, out_src2, out_waddr,
                      out_wen, out_illegal}), 128'(sb[0]));
        end
        after_rst = rst;
        if (rst) begin
            sb.delete(); exp_valid = 1'b0; exp_known = 1'b1;
        end else if (flush) begin
            sb.delete(); exp_valid = 1'b0;
        end else if (in_valid && rdy) begin
            if (sb.size() > 0) void'(sb.pop_front());
            sb.push_back(nb); exp_valid = 1'b1;
        end else if (out_ready && exp_valid) begin
            void'(sb.pop_front()); exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0] a, b, c;
        a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
            0: return enc_i(6'b001001, a, b, 16'($urandom));
            1: return enc_i(6'b001101, a, b, 16'($urandom));
            2: return enc_i(6'b001111, a, b, 16'($urandom));
            3: return enc_r(a, b, c, 6'b100001);
            4: return enc_r(a, b, c, 6'b100100);
            5: return enc_r(a, b, c, 6'b100101);
            6: return enc_r(a, b, c, 6'b101010);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        @(posedge clk);
        #1;
        rst = 1'b1; tick(); tick();
        rst = 1'b0;

        // ADDIU $2,$1,0xFFFF with $1 = 5
        in_valid = 1'b1; inst_addr = 32'h100; rf_rdata1 = 32'd5;
        inst = enc_i(6'b001001, 5'd1, 5'd2, 16'hFFFF); tick();
        // LUI $3,0x1234, then SPECIAL with an unknown func
        inst_addr = 32'h104; inst = enc_i(6'b001111, 5'd7, 5'd3, 16'h1234); tick();
        inst_addr = 32'h108; inst = enc_r(5'd1, 5'd2, 5'd3, 6'b111111); tick();
        // ORI zero-extension, AND, OR with $0 source, write to $0, unknown opcode
        inst_addr = 32'h10C; rf_rdata1 = 32'hF0F0_0000;
        inst = enc_i(6'b001101, 5'd1, 5'd5, 16'h8001); tick();
        inst_addr = 32'h110; rf_rdata1 = 32'hFF00_FF00; rf_rdata2 = 32'h0F0F_0F0F;
        inst = enc_r(5'd6, 5'd7, 5'd8, 6'b100100); tick();
        inst_addr = 32'h114; rf_rdata1 = 32'hDEAD_BEEF;
        inst = enc_r(5'd0, 5'd7, 5'd9, 6'b100101); tick();
        inst_addr = 32'h118; inst = enc_i(6'b001001, 5'd1, 5'd0, 16'h0005); tick();
        inst_addr = 32'h11C; inst = enc_i(6'b100011, 5'd1, 5'd2, 16'h0004); tick();
        in_valid = 1'b0; tick(); tick();

        // Back-pressure: hold for three cycles, then release
        in_valid = 1'b1; inst_addr = 32'h200; inst = enc_r(5'd1, 5'd2, 5'd10, 6'b100001); tick();
        out_ready = 1'b0; inst_addr = 32'h204; inst = enc_i(6'b001101, 5'd3, 5'd11, 16'h00FF);
        tick(); tick(); tick();
        out_ready = 1'b1; tick();
        in_valid = 1'b0; tick(); tick();

        // EX writeback targets $2 read by ADDU $4,$1,$2
        in_valid = 1'b1; inst_addr = 32'h300; rf_rdata1 = 32'd3; rf_rdata2 = 32'd7;
        inst = enc_r(5'd1, 5'd2, 5'd4, 6'b100001);
        ex_wen = 1'b1; ex_waddr = 5'd2; ex_wdata = 32'd9;
        tick(); tick(); tick();
        ex_wen = 1'b0; tick();
        in_valid = 1'b0; tick();
        // Writeback to $0 and to a register LUI does not read: never a hazard
        in_valid = 1'b1; ex_wen = 1'b1; ex_waddr = 5'd0;
        inst = enc_r(5'd0, 5'd0, 5'd4, 6'b100001); tick();
        ex_waddr = 5'd5; inst = enc_i(6'b001111, 5'd5, 5'd6, 16'hABCD); tick();
        ex_wen = 1'b0;

        // Flush while holding a bundle with a new instruction presented
        inst_addr = 32'h400; inst = enc_i(6'b001001, 5'd1, 5'd2, 16'h0010); tick();
        flush = 1'b1; inst_addr = 32'h404; inst = enc_i(6'b001001, 5'd1, 5'd3, 16'h0020); tick();
        flush = 1'b0; in_valid = 1'b0; tick();

        // Reset in the middle of a stalled transfer
        in_valid = 1'b1; out_ready = 1'b0; inst_addr = 32'h500; tick(); tick();
        rst = 1'b1; tick();
        rst = 1'b0; out_ready = 1'b1; tick(); tick();

        // Random traffic
        repeat (400) begin
            rst       = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ex_wen    = $urandom_range(0, 1) != 0;
            ex_waddr  = 5'($urandom_range(0, 7));
            ex_wdata  = $urandom;
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            inst_addr = $urandom;
            inst      = rand_inst();
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ex_wen = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
